// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// Ports (named from the unit's point of view):
//   valid_i, op_i, operand_a_i, operand_b_i, tag_i : request from the core
//   ready_o                                        : unit can accept a request
//   flush_i                                        : abort in-flight operation
//   valid_o, result_o, tag_o                       : result to the core
//   ready_i                                        : core accepts the result
//   busy_o                                         : operation in progress or pending
interface muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       op_i;
    logic [XLEN-1:0]  operand_a_i;
    logic [XLEN-1:0]  operand_b_i;
    logic [TAG_W-1:0] tag_i;
    logic             flush_i;
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;
    logic             busy_o;

    modport master (
        output valid_i, op_i, operand_a_i, operand_b_i, tag_i, flush_i, ready_i,
        input  ready_o, valid_o, result_o, tag_o, busy_o
    );

    modport slave (
        input  valid_i, op_i, operand_a_i, operand_b_i, tag_i, flush_i, ready_i,
        output ready_o, valid_o, result_o, tag_o, busy_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle. Divide-by-zero and signed overflow finish at accept.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : muldiv_if slave (request, result, flush, busy)
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic     clk_i,
    input  logic     rst_i,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [2:0]         op_r;
    logic               neg_r;       // result must be negated at the end
    logic [XLEN-1:0]    hi_r;        // product high half / partial remainder
    logic [XLEN-1:0]    lo_r;        // multiplier-product low half / dividend-quotient
    logic [XLEN-1:0]    b_r;         // |multiplicand| or |divisor|
    logic               valid_r;
    logic [XLEN-1:0]    result_r;
    logic [TAG_W-1:0]   tag_r;

    logic               accept_s, sgn_a_s, sgn_b_s, a_neg_s, b_neg_s, res_neg_s;
    logic               div_zero_s, overflow_s, special_s;
    logic [XLEN-1:0]    a_abs_s, b_abs_s, special_res_s;
    logic [XLEN:0]      mul_sum_s, div_shift_s, div_diff_s;
    logic [XLEN-1:0]    hi_nxt_s, lo_nxt_s, quot_fix_s, rem_fix_s, final_s;
    logic [2*XLEN-1:0]  prod_s, prod_fix_s;

    assign accept_s = (state_r == IDLE) && bus.valid_i && !bus.flush_i;

    // Operand signedness by opcode (MULHSU treats b as unsigned).
    always_comb begin
        sgn_a_s = 1'b0;
        sgn_b_s = 1'b0;
        case (bus.op_i)
            3'd1, 3'd4, 3'd6: begin
                sgn_a_s = 1'b1;
                sgn_b_s = 1'b1;
            end
            3'd2:    sgn_a_s = 1'b1;
            default: begin
                sgn_a_s = 1'b0;
                sgn_b_s = 1'b0;
            end
        endcase
    end

    assign a_neg_s    = sgn_a_s & bus.operand_a_i[XLEN-1];
    assign b_neg_s    = sgn_b_s & bus.operand_b_i[XLEN-1];
    assign a_abs_s    = a_neg_s ? -bus.operand_a_i : bus.operand_a_i;
    assign b_abs_s    = b_neg_s ? -bus.operand_b_i : bus.operand_b_i;
    // Remainder follows the dividend sign; everything else is sign(a)^sign(b).
    assign res_neg_s  = (bus.op_i[2] & bus.op_i[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
    assign div_zero_s = bus.op_i[2] & (bus.operand_b_i == ZERO);
    assign overflow_s = bus.op_i[2] & ~bus.op_i[0] & (bus.operand_a_i == MOST_NEG)
                        & (bus.operand_b_i == ALL_ONES);
    assign special_s  = div_zero_s | overflow_s;

    // Early-completion results for divide-by-zero and signed overflow.
    always_comb begin
        special_res_s = ZERO;
        if (div_zero_s) begin
            special_res_s = bus.op_i[1] ? bus.operand_a_i : ALL_ONES;
        end else begin
            special_res_s = bus.op_i[1] ? ZERO : MOST_NEG;
        end
    end

    // One iteration step: add-and-shift for multiply, restore-step for divide.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, b_r};
        hi_nxt_s    = hi_r;
        lo_nxt_s    = lo_r;
        if (op_r[2]) begin
            if (!div_diff_s[XLEN]) begin
                hi_nxt_s = div_diff_s[XLEN-1:0];
                lo_nxt_s = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt_s = div_shift_s[XLEN-1:0];
                lo_nxt_s = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nxt_s = mul_sum_s[XLEN:1];
            lo_nxt_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection applied on the last step's outputs.
    always_comb begin
        prod_s     = {hi_nxt_s, lo_nxt_s};
        prod_fix_s = neg_r ? -prod_s : prod_s;
        quot_fix_s = neg_r ? -lo_nxt_s : lo_nxt_s;
        rem_fix_s  = neg_r ? -hi_nxt_s : hi_nxt_s;
        final_s    = ZERO;
        if (!op_r[2]) begin
            if (op_r[1:0] == 2'd0) begin
                final_s = prod_fix_s[XLEN-1:0];
            end else begin
                final_s = prod_fix_s[2*XLEN-1:XLEN];
            end
        end else if (!op_r[1]) begin
            final_s = quot_fix_s;
        end else begin
            final_s = rem_fix_s;
        end
    end

    // Next-state logic; flush overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.flush_i) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.valid_i) begin
                        state_nxt_s = special_s ? DONE : CALC;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                CALC: begin
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, iteration datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= 3'd0;
            neg_r    <= 1'b0;
            hi_r     <= ZERO;
            lo_r     <= ZERO;
            b_r      <= ZERO;
            valid_r  <= 1'b0;
            result_r <= ZERO;
            tag_r    <= {TAG_W{1'b0}};
        end else begin
            if (accept_s) begin
                op_r  <= bus.op_i;
                neg_r <= res_neg_s;
                hi_r  <= ZERO;
                lo_r  <= a_abs_s;
                b_r   <= b_abs_s;
                cnt_r <= CNT_LOAD;
                tag_r <= bus.tag_i;
                if (special_s) begin
                    result_r <= special_res_s;
                end
            end else if ((state_r == CALC) && !bus.flush_i) begin
                hi_r  <= hi_nxt_s;
                lo_r  <= lo_nxt_s;
                cnt_r <= cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    result_r <= final_s;
                end
            end
            valid_r <= (state_nxt_s == DONE);
        end
    end

    assign bus.ready_o  = (state_r == IDLE);
    assign bus.busy_o   = (state_r == CALC) || (state_r == DONE);
    assign bus.valid_o  = valid_r;
    assign bus.result_o = result_r;
    assign bus.tag_o    = tag_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table of directed vectors plus
// hand-written sequences for result hold, flush and mid-operation reset.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    muldiv_if #(.XLEN(32), .TAG_W(5)) bus();

    muldiv_unit #(.XLEN(32), .TAG_W(5)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    // Issue one op at a negedge, measure latency, check result, hold, hand off.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp, input int lat,
                          input int hold, input string nm);
        int edges;
        logic [31:0] res0;
        logic [4:0]  tag0;
        chk({nm, "_ready_before"}, {31'd0, bus.ready_o}, 32'd1);
        bus.valid_i     = 1'b1;
        bus.op_i        = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        bus.tag_i       = tag;
        edges = 0;
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            bus.valid_i = 1'b0;
            if (bus.valid_o) break;
        end
        chk({nm, "_latency"}, 32'(edges), 32'(lat));
        chk({nm, "_result"}, bus.result_o, exp);
        chk({nm, "_tag"}, {27'd0, bus.tag_o}, {27'd0, tag});
        res0 = bus.result_o;
        tag0 = bus.tag_o;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk({nm, "_hold_valid"}, {31'd0, bus.valid_o}, 32'd1);
            chk({nm, "_hold_result"}, bus.result_o, res0);
            chk({nm, "_hold_tag"}, {27'd0, bus.tag_o}, {27'd0, tag0});
            chk({nm, "_hold_ready"}, {31'd0, bus.ready_o}, 32'd0);
        end
        bus.ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ready_i = 1'b0;
        chk({nm, "_valid_dropped"}, {31'd0, bus.valid_o}, 32'd0);
        chk({nm, "_ready_after"}, {31'd0, bus.ready_o}, 32'd1);
    endtask

    initial begin
        int bad;
        checks   = 0;
        failures = 0;
        vecs[0]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, 33};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 33};
        vecs[2]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0001, 33};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd9,  32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd10, 32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,         32'd0,         5'd12, 32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1};
        vecs[12] = '{3'd0, 32'h1234_5678, 32'h0000_0010, 5'd15, 32'h2345_6780, 33};
        vecs[13] = '{3'd4, 32'h8000_0000, 32'h0000_0002, 5'd16, 32'hC000_0000, 33};
        vecs[14] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 5'd17, 32'h0000_000F, 33};
        vecs[15] = '{3'd1, 32'hFFFF_FFFD, 32'h0000_0005, 5'd18, 32'hFFFF_FFFF, 33};
        vecs[16] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 5'd19, 32'h0000_0001, 33};

        rst             = 1'b1;
        bus.valid_i     = 1'b0;
        bus.op_i        = 3'd0;
        bus.operand_a_i = 32'd0;
        bus.operand_b_i = 32'd0;
        bus.tag_i       = 5'd0;
        bus.flush_i     = 1'b0;
        bus.ready_i     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_valid",  {31'd0, bus.valid_o}, 32'd0);
        chk("reset_busy",   {31'd0, bus.busy_o},  32'd0);
        chk("reset_ready",  {31'd0, bus.ready_o}, 32'd1);
        chk("reset_result", bus.result_o, 32'd0);
        chk("reset_tag",    {27'd0, bus.tag_o}, 32'd0);

        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp,
                   vecs[i].lat, 0, $sformatf("vec%0d", i));
        end

        // Result held while the consumer stalls.
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 32'hFFFF_FFFE, 33, 4, "hold");

        // Flush at CALC cycle 10 with a competing request.
        bus.valid_i     = 1'b1;
        bus.op_i        = 3'd5;
        bus.operand_a_i = 32'd1000;
        bus.operand_b_i = 32'd3;
        bus.tag_i       = 5'd22;
        @(posedge clk);
        @(negedge clk);
        chk("flush_busy_calc", {31'd0, bus.busy_o}, 32'd1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        bus.op_i    = 3'd0;
        bus.tag_i   = 5'd23;
        @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("flush_ready", {31'd0, bus.ready_o}, 32'd1);
        chk("flush_busy",  {31'd0, bus.busy_o},  32'd0);
        chk("flush_valid", {31'd0, bus.valid_o}, 32'd0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.valid_o || bus.busy_o) bad++;
        end
        chk("flush_no_activity", 32'(bad), 32'd0);
        run_op(3'd5, 32'd1000, 32'd3, 5'd24, 32'd333, 33, 0, "post_flush");

        // Reset in the middle of CALC.
        bus.valid_i     = 1'b1;
        bus.op_i        = 3'd3;
        bus.operand_a_i = 32'hFFFF_FFFF;
        bus.operand_b_i = 32'hFFFF_FFFF;
        bus.tag_i       = 5'd25;
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid",  {31'd0, bus.valid_o}, 32'd0);
        chk("midrst_busy",   {31'd0, bus.busy_o},  32'd0);
        chk("midrst_ready",  {31'd0, bus.ready_o}, 32'd1);
        chk("midrst_result", bus.result_o, 32'd0);
        chk("midrst_tag",    {27'd0, bus.tag_o}, 32'd0);
        run_op(3'd7, 32'd100, 32'd7, 5'd26, 32'd2, 33, 0, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
